// File: rtl/pwm_cok_kanalli_denetleyici_if.sv
// Wishbone classic slave bundle for the multi-channel PWM controller.
// The master drives the request side; the slave returns data and ack.
interface pwm_cok_kanalli_denetleyici_if #(
  parameter int ADR_W = 8
) ();
  logic [ADR_W-1:0] adr;
  logic [31:0]      dat_w;
  logic [31:0]      dat_r;
  logic             we;
  logic             cyc;
  logic             stb;
  logic [3:0]       sel;
  logic             ack;

  modport master (output adr, dat_w, we, cyc, stb, sel, input dat_r, ack);
  modport slave  (input adr, dat_w, we, cyc, stb, sel, output dat_r, ack);
endinterface

// File: rtl/pwm_cok_kanalli_denetleyici.sv
// Wishbone PWM controller: KANAL channels with standard, heartbeat and one-shot
// modes, shadowed period/thresholds committed at the period boundary.
module pwm_cok_kanalli_denetleyici #(
  parameter int KANAL      = 4,
  parameter int COZUNURLUK = 32,
  parameter int ADR_W      = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  pwm_cok_kanalli_denetleyici_if.slave       wb,
  output logic [KANAL-1:0]                   pwm_o,
  output logic                               irq_o
);

  localparam int CW = ADR_W - 5;
  // Heartbeat arithmetic needs one carry bit above the counter and must hold a full STEP.
  localparam int AW = (COZUNURLUK + 1 > 13) ? COZUNURLUK + 1 : 13;

  typedef logic [COZUNURLUK-1:0] val_t;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_STD  = 2'd1,
    MODE_HB   = 2'd2,
    MODE_ONE  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PERIOD = 3'd1,
    REG_THR1   = 3'd2,
    REG_THR2   = 3'd3,
    REG_STEP   = 3'd4,
    REG_STATUS = 3'd5,
    REG_COUNT  = 3'd6,
    REG_RSVD   = 3'd7
  } reg_e;

  logic             req;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic [31:0]      rd_data;
  logic [CW-1:0]    ch_idx;
  reg_e             reg_idx;
  logic [31:0]      rd_vec [KANAL];
  logic [KANAL-1:0] irq_vec;
  logic             unused_adr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign req        = wb.cyc & wb.stb & ~ack_q;
  assign ch_idx     = wb.adr[ADR_W-1:5];
  assign reg_idx    = reg_e'(wb.adr[4:2]);
  assign unused_adr = &{1'b0, wb.adr[1:0]};

  for (genvar c = 0; c < KANAL; c++) begin : g_ch
    mode_e       mode;
    logic        pol;
    logic        irq_en;
    logic        pending;
    logic        done;
    logic        dir_up;
    logic        pwm_q;
    val_t        sh_period, sh_thr1, sh_thr2;
    val_t        act_period, act_thr1, act_thr2;
    val_t        cnt;
    val_t        duty;
    logic [11:0] step;

    logic          wr;
    logic          running;
    logic          boundary;
    logic          set_done;
    logic          restart;
    logic          raw;
    logic [3:0]    ctrl_new;
    logic [31:0]   wr_merged;
    logic [AW-1:0] up_sum;
    logic [AW-1:0] dn_diff;
    logic [31:0]   rd;

    assign wr        = req & wb.we & (ch_idx == CW'(c));
    assign ctrl_new  = wb.dat_w[3:0];
    assign running   = (mode != MODE_IDLE) && (act_period != '0) &&
                       !((mode == MODE_ONE) && done);
    assign boundary  = running && (cnt == act_period - val_t'(1));
    assign set_done  = boundary && (mode == MODE_ONE);
    // Rewriting one-shot mode is the software's way to fire another pulse.
    assign restart   = wr && (reg_idx == REG_CTRL) && wb.sel[0] &&
                       ((mode_e'(ctrl_new[1:0]) != mode) || (ctrl_new[1:0] == 2'd3));
    assign up_sum    = AW'(duty) + AW'(step);
    assign dn_diff   = AW'(duty) - AW'(step);

    always_comb begin
      wr_merged = '0;
      case (reg_idx)
        REG_PERIOD: wr_merged = merge_bytes(32'(sh_period), wb.dat_w, wb.sel);
        REG_THR1:   wr_merged = merge_bytes(32'(sh_thr1), wb.dat_w, wb.sel);
        REG_THR2:   wr_merged = merge_bytes(32'(sh_thr2), wb.dat_w, wb.sel);
        REG_STEP:   wr_merged = merge_bytes(32'(step), wb.dat_w, wb.sel);
        default:    wr_merged = '0;
      endcase
    end

    // NOTE: raw gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
      raw = 1'b0;
      if (running) begin
        case (mode)
          MODE_STD: raw = cnt < act_thr1;
          MODE_HB:  raw = cnt < duty;
          MODE_ONE: raw = cnt < act_thr1;
          default:  raw = 1'b0;
        endcase
      end
    end

    // NOTE: every channel register is reset, shadows included, so no pending update outlives rst_i.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mode       <= MODE_IDLE;
        pol        <= 1'b0;
        irq_en     <= 1'b0;
        pending    <= 1'b0;
        done       <= 1'b0;
        dir_up     <= 1'b0;
        pwm_q      <= 1'b0;
        sh_period  <= '0;
        sh_thr1    <= '0;
        sh_thr2    <= '0;
        act_period <= '0;
        act_thr1   <= '0;
        act_thr2   <= '0;
        cnt        <= '0;
        duty       <= '0;
        step       <= '0;
      end else begin
        pwm_q <= raw ^ pol;
        cnt   <= (running && !boundary) ? cnt + val_t'(1) : '0;

        if (boundary) begin
          act_period <= sh_period;
          act_thr1   <= sh_thr1;
          act_thr2   <= sh_thr2;
          pending    <= 1'b0;
          if (set_done) done <= 1'b1;
          // Duty walks between THR1 and THR2 using the thresholds of the period just ending.
          if (mode == MODE_HB) begin
            if (act_thr2 <= act_thr1) begin
              duty <= act_thr1;
            end else if (dir_up) begin
              if (up_sum >= AW'(act_thr2)) begin
                duty   <= act_thr2;
                dir_up <= 1'b0;
              end else begin
                duty <= val_t'(up_sum);
              end
            end else begin
              if (dn_diff[AW-1] || (dn_diff <= AW'(act_thr1))) begin
                duty   <= act_thr1;
                dir_up <= 1'b1;
              end else begin
                duty <= val_t'(dn_diff);
              end
            end
          end
        end

        // Bus writes come last so a shadow write in the boundary cycle keeps pending set.
        if (wr) begin
          case (reg_idx)
            REG_CTRL: begin
              if (wb.sel[0]) begin
                mode   <= mode_e'(ctrl_new[1:0]);
                pol    <= ctrl_new[2];
                irq_en <= ctrl_new[3];
              end
              if (restart) begin
                cnt        <= '0;
                act_period <= sh_period;
                act_thr1   <= sh_thr1;
                act_thr2   <= sh_thr2;
                pending    <= 1'b0;
                duty       <= sh_thr1;
                dir_up     <= 1'b1;
                done       <= 1'b0;
              end
            end
            REG_PERIOD: begin
              sh_period <= val_t'(wr_merged);
              pending   <= 1'b1;
            end
            REG_THR1: begin
              sh_thr1 <= val_t'(wr_merged);
              pending <= 1'b1;
            end
            REG_THR2: begin
              sh_thr2 <= val_t'(wr_merged);
              pending <= 1'b1;
            end
            REG_STEP: step <= 12'(wr_merged);
            REG_STATUS: begin
              if (wb.sel[0] && wb.dat_w[1] && !set_done) done <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end

    always_comb begin
      rd = '0;
      case (reg_idx)
        REG_CTRL:   rd[3:0] = {irq_en, pol, mode};
        REG_PERIOD: rd = 32'(sh_period);
        REG_THR1:   rd = 32'(sh_thr1);
        REG_THR2:   rd = 32'(sh_thr2);
        REG_STEP:   rd[11:0] = step;
        REG_STATUS: rd[2:0] = {pending, done, pwm_q};
        REG_COUNT:  rd = 32'(cnt);
        REG_RSVD:   rd = '0;
        default:    rd = '0;
      endcase
    end

    assign rd_vec[c]  = rd;
    assign pwm_o[c]   = pwm_q;
    assign irq_vec[c] = done & irq_en;
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < KANAL; c++) begin
      if (ch_idx == CW'(c)) rd_data = rd_vec[c];
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_o <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb.we) ? rd_data : '0;
      irq_o <= |irq_vec;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_r = dat_q;

endmodule

// File: tb/tb_pwm_cok_kanalli_denetleyici.sv
// Directed bench for pwm_cok_kanalli_denetleyici: integer-level channel model
// compared every cycle, plus hand-computed waveform and register expectations.
module tb_pwm_cok_kanalli_denetleyici;
  localparam int KANAL = 4;
  localparam int COZ   = 32;
  localparam int ADR_W = 8;
  localparam longint RES_MASK = (COZ >= 32) ? 64'hFFFF_FFFF : ((64'd1 << COZ) - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [KANAL-1:0] pwm;
  logic irq;

  always #5 clk = ~clk;

  pwm_cok_kanalli_denetleyici_if #(.ADR_W(ADR_W)) wb ();

  pwm_cok_kanalli_denetleyici #(.KANAL(KANAL), .COZUNURLUK(COZ), .ADR_W(ADR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb),
    .pwm_o (pwm),
    .irq_o (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- behavioural model (integer arithmetic) ----------------
  longint m_mode [KANAL], m_pol [KANAL], m_ien [KANAL];
  longint m_sp [KANAL], m_st1 [KANAL], m_st2 [KANAL];
  longint m_ap [KANAL], m_at1 [KANAL], m_at2 [KANAL];
  longint m_step [KANAL], m_pend [KANAL], m_done [KANAL];
  longint m_cnt [KANAL], m_duty [KANAL], m_up [KANAL], m_pwm [KANAL];
  bit     m_ack;
  bit     m_irq;
  longint m_rd;

  function automatic longint merge(input longint old_v, input longint d, input longint sel);
    longint m = 0;
    for (int b = 0; b < 4; b++) if (((sel >> b) & 1) != 0) m |= longint'(255) << (8 * b);
    return ((old_v & ~m) | (d & m)) & 64'hFFFF_FFFF;
  endfunction

  function automatic longint model_read(input int c, input longint rg);
    case (rg)
      0: return m_mode[c] | (m_pol[c] << 2) | (m_ien[c] << 3);
      1: return m_sp[c];
      2: return m_st1[c];
      3: return m_st2[c];
      4: return m_step[c];
      5: return m_pwm[c] | (m_done[c] << 1) | (m_pend[c] << 2);
      6: return m_cnt[c];
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    bit req, we, run, bnd, raw, fired;
    longint a, d, sel, ch, rg, s, nm;
    bit nirq;
    longint nrd;
    if (rst) begin
      for (int c = 0; c < KANAL; c++) begin
        m_mode[c] = 0; m_pol[c] = 0; m_ien[c] = 0; m_sp[c] = 0; m_st1[c] = 0; m_st2[c] = 0;
        m_ap[c] = 0; m_at1[c] = 0; m_at2[c] = 0; m_step[c] = 0; m_pend[c] = 0; m_done[c] = 0;
        m_cnt[c] = 0; m_duty[c] = 0; m_up[c] = 0; m_pwm[c] = 0;
      end
      m_ack = 0; m_irq = 0; m_rd = 0;
      return;
    end
    req = wb.cyc && wb.stb && !m_ack;
    we  = wb.we;
    a   = longint'(wb.adr);
    d   = longint'(wb.dat_w);
    sel = longint'(wb.sel);
    ch  = a >> 5;
    rg  = (a >> 2) & 7;
    nirq = 0;
    for (int c = 0; c < KANAL; c++) if (m_done[c] != 0 && m_ien[c] != 0) nirq = 1;
    nrd = 0;
    if (req && !we && ch < KANAL) nrd = model_read(int'(ch), rg);
    for (int c = 0; c < KANAL; c++) begin
      run = (m_mode[c] != 0) && (m_ap[c] > 0) && !(m_mode[c] == 3 && m_done[c] != 0);
      bnd = run && (m_cnt[c] == m_ap[c] - 1);
      raw = 0;
      if (run) raw = (m_mode[c] == 2) ? (m_cnt[c] < m_duty[c]) : (m_cnt[c] < m_at1[c]);
      fired = bnd && (m_mode[c] == 3);
      if (bnd) begin
        if (m_mode[c] == 2) begin
          if (m_at2[c] <= m_at1[c]) m_duty[c] = m_at1[c];
          else if (m_up[c] != 0) begin
            s = m_duty[c] + m_step[c];
            if (s >= m_at2[c]) begin m_duty[c] = m_at2[c]; m_up[c] = 0; end
            else m_duty[c] = s;
          end else begin
            s = m_duty[c] - m_step[c];
            if (s <= m_at1[c]) begin m_duty[c] = m_at1[c]; m_up[c] = 1; end
            else m_duty[c] = s;
          end
        end
        if (fired) m_done[c] = 1;
        m_ap[c] = m_sp[c]; m_at1[c] = m_st1[c]; m_at2[c] = m_st2[c]; m_pend[c] = 0;
      end
      m_cnt[c] = (run && !bnd) ? m_cnt[c] + 1 : 0;
      m_pwm[c] = raw ^ m_pol[c][0];
      if (req && we && ch == c) begin
        case (rg)
          0: if ((sel & 1) != 0) begin
            nm = d & 3;
            if (nm != m_mode[c] || nm == 3) begin
              m_cnt[c] = 0; m_ap[c] = m_sp[c]; m_at1[c] = m_st1[c]; m_at2[c] = m_st2[c];
              m_pend[c] = 0; m_duty[c] = m_st1[c]; m_up[c] = 1; m_done[c] = 0;
            end
            m_mode[c] = nm; m_pol[c] = (d >> 2) & 1; m_ien[c] = (d >> 3) & 1;
          end
          1: begin m_sp[c]  = merge(m_sp[c], d, sel) & RES_MASK;  m_pend[c] = 1; end
          2: begin m_st1[c] = merge(m_st1[c], d, sel) & RES_MASK; m_pend[c] = 1; end
          3: begin m_st2[c] = merge(m_st2[c], d, sel) & RES_MASK; m_pend[c] = 1; end
          4: m_step[c] = merge(m_step[c], d, sel) & 64'hFFF;
          5: if ((sel & 1) != 0 && (d & 2) != 0 && !fired) m_done[c] = 0;
          default: ;
        endcase
      end
    end
    m_ack = req;
    m_rd  = nrd;
    m_irq = nirq;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial forever begin
    longint ev;
    @(negedge clk);
    ev = 0;
    for (int c = 0; c < KANAL; c++) ev |= (m_pwm[c] & 1) << c;
    check("pwm_o", longint'(pwm), ev);
    check("irq_o", longint'(irq), longint'(m_irq));
    check("ack", longint'(wb.ack), longint'(m_ack));
    if (m_ack) check("rdata", longint'(wb.dat_r), m_rd);
  end

  // ---------------- bus and measurement helpers ----------------
  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic w,
                     input logic [3:0] s, output logic [31:0] q);
    int t = 0;
    wb.adr = a; wb.dat_w = d; wb.we = w; wb.sel = s; wb.cyc = 1'b1; wb.stb = 1'b1;
    @(negedge clk);
    check("ack_latency", longint'(wb.ack), 1);
    while (!wb.ack && t < 8) begin @(negedge clk); t++; end
    if (!wb.ack) timeout("ack_wait");
    q = wb.dat_r;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(a, d, 1'b1, 4'hF, q);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] q);
    bus(a, 32'h0, 1'b0, 4'hF, q);
  endtask

  task automatic count_high(input int ch, input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin @(negedge clk); k += int'(pwm[ch]); end
  endtask

  task automatic run_len(input int ch, output int len);
    int t = 0;
    len = 0;
    while (!pwm[ch] && t < 400) begin @(negedge clk); t++; end
    while (pwm[ch] && len < 300) begin len++; @(negedge clk); end
  endtask

  task automatic wait_mcnt(input int ch, input longint v);
    for (int i = 0; i < 300; i++) begin
      if (m_cnt[ch] == v) return;
      @(negedge clk);
    end
    timeout("wait_cnt");
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] q;
    logic [9:0]  bits;
    int k, len;
    int hb_exp [5] = '{10, 25, 40, 25, 10};

    wb.adr = '0; wb.dat_w = '0; wb.we = 1'b0; wb.sel = 4'h0; wb.cyc = 1'b0; wb.stb = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_pwm", longint'(pwm), 0);
    check("rst_irq", longint'(irq), 0);
    for (int r = 0; r < 8; r++) begin
      rd(8'(r * 4), q);
      check("rst_reg", longint'(q), 0);
    end
    rd(8'hFC, q);
    check("unmapped_fc", longint'(q), 0);

    // Standard mode, then polarity inverted without restart.
    wr(8'h04, 32'd10);
    wr(8'h08, 32'd3);
    wr(8'h00, 32'd1);
    for (int i = 0; i < 10; i++) begin bits[i] = pwm[0]; @(negedge clk); end
    check("std_waveform", longint'(bits), 10'b00_0000_0111);
    count_high(0, 10, k);
    check("std_high_cnt", k, 3);
    wr(8'h00, 32'd5);
    count_high(0, 10, k);
    check("inv_high_cnt", k, 7);
    wr(8'h00, 32'd1);

    // Shadow threshold update on ch1.
    wr(8'h24, 32'd10);
    wr(8'h28, 32'd3);
    wr(8'h20, 32'd1);
    wait_mcnt(1, 2);
    wr(8'h28, 32'd7);
    rd(8'h34, q);
    check("pending_set", longint'((q >> 2) & 1), 1);
    repeat (20) @(negedge clk);
    rd(8'h34, q);
    check("pending_clr", longint'((q >> 2) & 1), 0);
    count_high(1, 10, k);
    check("thr7_high_cnt", k, 7);
    wait_mcnt(1, 9);
    wr(8'h28, 32'd2);
    rd(8'h34, q);
    check("pending_boundary", longint'((q >> 2) & 1), 1);
    wait_mcnt(1, 9);
    count_high(1, 10, k);
    check("thr2_high_cnt", k, 2);

    // Heartbeat on ch2.
    wr(8'h44, 32'd100);
    wr(8'h48, 32'd10);
    wr(8'h4C, 32'd40);
    wr(8'h50, 32'd15);
    wr(8'h40, 32'd2);
    for (int i = 0; i < 5; i++) begin
      run_len(2, len);
      check("hb_duty", len, hb_exp[i]);
    end
    wr(8'h50, 32'd0);
    wr(8'h40, 32'd1);
    wr(8'h40, 32'd2);
    run_len(2, len);
    for (int i = 0; i < 2; i++) begin
      run_len(2, len);
      check("hb_step0", len, 10);
    end

    // One-shot with interrupt on ch3.
    wr(8'h64, 32'd20);
    wr(8'h68, 32'd5);
    wr(8'h60, 32'hB);
    run_len(3, len);
    check("oneshot_len", len, 5);
    repeat (20) @(negedge clk);
    check("oneshot_irq", longint'(irq), 1);
    rd(8'h74, q);
    check("oneshot_status", longint'(q), 2);
    wr(8'h74, 32'h2);
    check("w1c_irq", longint'(irq), 0);
    wr(8'h60, 32'hB);
    run_len(3, len);
    check("oneshot_retrig", len, 5);

    // Byte-lane write and zero period.
    wr(8'h04, 32'h0);
    begin
      logic [31:0] dq;
      bus(8'h04, 32'hAABB_CCDD, 1'b1, 4'b0001, dq);
    end
    rd(8'h04, q);
    check("sel_period", longint'(q), 32'hDD);
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h0);
    wr(8'h00, 32'h1);
    count_high(0, 10, k);
    check("p0_high_cnt", k, 0);
    rd(8'h18, q);
    check("p0_count", longint'(q), 0);

    // Reset in the middle of heartbeat and a latched one-shot interrupt.
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", longint'(pwm), 0);
    check("midrst_irq", longint'(irq), 0);
    rst = 1'b0;
    rd(8'h44, q);
    check("midrst_period", longint'(q), 0);
    rd(8'h34, q);
    check("midrst_status", longint'(q), 0);
    rd(8'h60, q);
    check("midrst_ctrl", longint'(q), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
